// File: rtl/countdown_timer_module.sv
// -----------------------------------------------------------------------------
// countdown_timer_module
//
// BCD countdown timer. An hh:mm:ss preset is entered one field at a time with
// an increment button. A run/pause pulse starts the countdown, which then drops
// by one centisecond per clk_i. When the count reaches 00:00:00.00 the timer
// stops and raises alarm_o. The eight digit outputs use the same order as the
// stopwatch, so both blocks can drive one display mux.
//
// Parameters
//   ALARM_CYCLES        clk_i cycles alarm_o stays high after expiry.
//                       0 keeps the alarm on until a button pulse arrives.
//
// Ports
//   clk_i               centisecond tick clock; all state changes on its rising edge
//   nreset_i            asynchronous active-low master reset
//   run_pause_button_i  1-cycle pulse: start / pause / resume
//   timer_reset_i       1-cycle pulse: reload the preset and return to SET
//   set_field_i         preset field to edit: 0=sec 1=min 2=hr 3=none
//   set_inc_button_i    1-cycle pulse: increment the selected preset field
//   centisec_o..decahr_o  BCD digits, least significant first
//   running_o           high while the timer is counting
//   alarm_o             high while the expiry alarm is active
//   state_o             current FSM state, exported for debug
//
// Handshake: there are no valid/ready channels. Every input is a single-cycle
// pulse sampled on the rising edge of clk_i. Its effect is visible on the
// outputs after that edge.
// -----------------------------------------------------------------------------
module countdown_timer_module #(
   parameter int unsigned ALARM_CYCLES = 500
) (
   input  logic       clk_i,
   input  logic       nreset_i,
   input  logic       run_pause_button_i,
   input  logic       timer_reset_i,
   input  logic [1:0] set_field_i,
   input  logic       set_inc_button_i,
   output logic [3:0] centisec_o,
   output logic [3:0] decisec_o,
   output logic [3:0] sec_o,
   output logic [3:0] decasec_o,
   output logic [3:0] min_o,
   output logic [3:0] decamin_o,
   output logic [3:0] hr_o,
   output logic [3:0] decahr_o,
   output logic       running_o,
   output logic       alarm_o,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      ST_SET     = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } state_e;

   // The alarm counter is loaded with ALARM_CYCLES-1 on expiry. alarm_o drops
   // on the edge after the counter reaches zero, so it stays high for exactly
   // ALARM_CYCLES cycles.
   localparam int unsigned ACW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
   localparam logic [ACW-1:0] ALARM_LOAD =
      (ALARM_CYCLES > 0) ? ACW'(ALARM_CYCLES - 1) : '0;

   // Largest value of each digit, index 0 = centisec ... 7 = decahr.
   localparam logic [7:0][3:0] DIGIT_MAX =
      {4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

   state_e           state_q, state_d;
   logic [7:0][3:0]  cnt_q, cnt_d;         // displayed digits
   logic [5:0][3:0]  preset_q, preset_d;   // sec ones .. hr tens
   logic             alarm_q, alarm_d;
   logic [ACW-1:0]   alarm_cnt_q, alarm_cnt_d;
   logic             running_q, running_d;

   logic [7:0][3:0]  dec_val;
   logic             dec_zero;
   logic [5:0][3:0]  preset_inc;

   // Advance one BCD pair. The ones digit wraps 9->0 and carries into the tens
   // digit. The tens digit wraps at tens_max, so one call covers both 59 and 99.
   function automatic logic [7:0] inc_pair(input logic [7:0] pair,
                                           input logic [3:0] tens_max);
      logic [3:0] ones;
      logic [3:0] tens;
      ones = pair[3:0];
      tens = pair[7:4];
      if (ones == 4'd9) begin
         ones = 4'd0;
         tens = (tens == tens_max) ? 4'd0 : tens + 4'd1;
      end else begin
         ones = ones + 4'd1;
      end
      return {tens, ones};
   endfunction

   // Ripple-borrow decrement across all eight digits. A digit borrows from the
   // next one only when it wraps from 0 to its maximum.
   always_comb begin
      logic borrow;
      borrow  = 1'b1;
      dec_val = cnt_q;
      for (int i = 0; i < 8; i++) begin
         if (borrow) begin
            if (cnt_q[i] == 4'd0) begin
               dec_val[i] = DIGIT_MAX[i];
            end else begin
               dec_val[i] = cnt_q[i] - 4'd1;
               borrow     = 1'b0;
            end
         end
      end
   end

   assign dec_zero = (dec_val == '0);

   // Preset after an increment of the selected field. Fields do not carry into
   // each other.
   always_comb begin
      preset_inc = preset_q;
      case (set_field_i)
         2'd0: {preset_inc[1], preset_inc[0]} = inc_pair({preset_q[1], preset_q[0]}, 4'd5);
         2'd1: {preset_inc[3], preset_inc[2]} = inc_pair({preset_q[3], preset_q[2]}, 4'd5);
         2'd2: {preset_inc[5], preset_inc[4]} = inc_pair({preset_q[5], preset_q[4]}, 4'd9);
         default: preset_inc = preset_q;
      endcase
   end

   // Next-state logic. Pulse priority is timer_reset > reaching zero >
   // run_pause > set_inc.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      preset_d    = preset_q;
      alarm_d     = alarm_q;
      alarm_cnt_d = alarm_cnt_q;

      if (timer_reset_i) begin
         state_d = ST_SET;
         cnt_d   = {preset_q, 8'h00};
         alarm_d = 1'b0;
      end else begin
         case (state_q)
            ST_SET: begin
               // The display tracks the preset. Starting just keeps the value
               // already shown, so the first decrement happens on the next edge.
               if (run_pause_button_i) begin
                  if (preset_q != '0) state_d = ST_RUN;
                  cnt_d = {preset_q, 8'h00};
               end else if (set_inc_button_i) begin
                  preset_d = preset_inc;
                  cnt_d    = {preset_inc, 8'h00};
               end else begin
                  cnt_d = {preset_q, 8'h00};
               end
            end
            ST_RUN: begin
               // Expiry beats a simultaneous pause, and the count never wraps.
               if (dec_zero) begin
                  state_d     = ST_EXPIRED;
                  cnt_d       = '0;
                  alarm_d     = 1'b1;
                  alarm_cnt_d = ALARM_LOAD;
               end else if (run_pause_button_i) begin
                  state_d = ST_PAUSE;
               end else begin
                  cnt_d = dec_val;
               end
            end
            ST_PAUSE: begin
               if (run_pause_button_i) state_d = ST_RUN;
            end
            ST_EXPIRED: begin
               if (run_pause_button_i || set_inc_button_i) begin
                  state_d = ST_SET;
                  cnt_d   = {preset_q, 8'h00};
                  alarm_d = 1'b0;
               end else if (alarm_q && (ALARM_CYCLES != 0)) begin
                  if (alarm_cnt_q == '0) alarm_d = 1'b0;
                  else alarm_cnt_d = alarm_cnt_q - ACW'(1);
               end
            end
            default: state_d = ST_SET;
         endcase
      end

      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q     <= ST_SET;
         cnt_q       <= '0;
         preset_q    <= '0;
         alarm_q     <= 1'b0;
         alarm_cnt_q <= '0;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         preset_q    <= preset_d;
         alarm_q     <= alarm_d;
         alarm_cnt_q <= alarm_cnt_d;
         running_q   <= running_d;
      end
   end

   assign centisec_o = cnt_q[0];
   assign decisec_o  = cnt_q[1];
   assign sec_o      = cnt_q[2];
   assign decasec_o  = cnt_q[3];
   assign min_o      = cnt_q[4];
   assign decamin_o  = cnt_q[5];
   assign hr_o       = cnt_q[6];
   assign decahr_o   = cnt_q[7];
   assign running_o  = running_q;
   assign alarm_o    = alarm_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_countdown_timer_module.sv
// -----------------------------------------------------------------------------
// Bench for countdown_timer_module. Inputs change on the falling edge of clk
// and outputs are sampled on the falling edge. The display is packed as
// 32'hHHMMSSCC, so 32'h00000300 reads 00:00:03.00.
// -----------------------------------------------------------------------------
module tb_countdown_timer_module;

   localparam int ALARM = 500;
   localparam logic [1:0] S_SET = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_EXP = 2'd3;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       run_pause = 1'b0;
   logic       treset = 1'b0;
   logic [1:0] set_field = 2'd3;
   logic       set_inc = 1'b0;
   logic [3:0] centisec, decisec, sec, decasec, min, decamin, hr, decahr;
   logic       running, alarm;
   logic [1:0] state;

   int n_pass = 0;
   int n_total = 0;
   int p_sec = 0, p_min = 0, p_hr = 0;   // bench copy of the preset
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   countdown_timer_module #(.ALARM_CYCLES(ALARM)) dut (
      .clk_i(clk), .nreset_i(nreset), .run_pause_button_i(run_pause),
      .timer_reset_i(treset), .set_field_i(set_field), .set_inc_button_i(set_inc),
      .centisec_o(centisec), .decisec_o(decisec), .sec_o(sec), .decasec_o(decasec),
      .min_o(min), .decamin_o(decamin), .hr_o(hr), .decahr_o(decahr),
      .running_o(running), .alarm_o(alarm), .state_o(state)
   );

   function automatic logic [31:0] disp();
      return {decahr, hr, decamin, min, decasec, sec, decisec, centisec};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_run();
      run_pause = 1'b1;
      @(negedge clk);
      run_pause = 1'b0;
   endtask

   task automatic pulse_inc(input logic [1:0] f);
      set_field = f;
      set_inc = 1'b1;
      @(negedge clk);
      set_inc = 0;
      @(negedge clk);
   endtask

   task automatic set_to(input int hh, input int mm, input int ss);
      repeat ((ss - p_sec + 60) % 60) pulse_inc(2'd0);
      repeat ((mm - p_min + 60) % 60) pulse_inc(2'd1);
      repeat ((hh - p_hr + 100) % 100) pulse_inc(2'd2);
      p_sec = ss; p_min = mm; p_hr = hh;
      set_field = 2'd3;
   endtask

   task automatic test_reset();
      tick(2);
      nreset = 1'b1;
      tick(1);
      n_total++; if (disp() !== 32'h0) $display("FAIL reset_digits: got %h exp 00000000", disp()); else n_pass++;
      n_total++; if (alarm !== 1'b0 || running !== 1'b0) $display("FAIL reset_flags: alarm %b running %b exp 0 0", alarm, running); else n_pass++;
      n_total++; if (state !== S_SET) $display("FAIL reset_state: got %0d exp %0d", state, S_SET); else n_pass++;
   endtask

   task automatic test_basic_countdown();
      set_to(0, 0, 3);
      n_total++; if (disp() !== 32'h00000300) $display("FAIL set_3s: got %h exp 00000300", disp()); else n_pass++;
      pulse_run();
      n_total++; if (disp() !== 32'h00000300 || running !== 1'b1) $display("FAIL run_load: got %h run %b exp 00000300 1", disp(), running); else n_pass++;
      tick(299);
      n_total++; if (disp() !== 32'h00000001 || alarm !== 1'b0) $display("FAIL one_left: got %h alarm %b exp 00000001 0", disp(), alarm); else n_pass++;
      tick(1);
      n_total++; if (disp() !== 32'h0 || alarm !== 1'b1 || state !== S_EXP || running !== 1'b0)
         $display("FAIL expiry: got %h alarm %b state %0d run %b exp 00000000 1 3 0", disp(), alarm, state, running); else n_pass++;
   endtask

   task automatic test_alarm_length();
      int n_high;
      n_high = 0;
      for (int i = 0; i < ALARM + 50; i++) begin
         if (!alarm) break;
         n_high++;
         @(negedge clk);
      end
      n_total++; if (n_high != ALARM) $display("FAIL alarm_len: got %0d exp %0d", n_high, ALARM); else n_pass++;
      n_total++; if (state !== S_EXP || disp() !== 32'h0) $display("FAIL alarm_after: state %0d digits %h exp 3 00000000", state, disp()); else n_pass++;
      treset = 1'b1; @(negedge clk); treset = 1'b0;
      n_total++; if (state !== S_SET || disp() !== 32'h00000300) $display("FAIL treset_exp: state %0d digits %h exp 0 00000300", state, disp()); else n_pass++;
   endtask

   task automatic test_borrow();
      set_to(0, 1, 0);
      n_total++; if (disp() !== 32'h00010000) $display("FAIL set_1m: got %h exp 00010000", disp()); else n_pass++;
      pulse_run();
      exp_q.push_back(32'h00005999);
      exp_q.push_back(32'h00005998);
      exp_q.push_back(32'h00005997);
      while (exp_q.size() > 0) begin
         logic [31:0] e;
         tick(1);
         e = exp_q.pop_front();
         n_total++; if (disp() !== e) $display("FAIL borrow_min: got %h exp %h", disp(), e); else n_pass++;
      end
      treset = 1'b1; @(negedge clk); treset = 1'b0;
      n_total++; if (disp() !== 32'h00010000 || state !== S_SET) $display("FAIL treset_run: got %h state %0d exp 00010000 0", disp(), state); else n_pass++;
      set_to(1, 0, 0);
      pulse_run();
      tick(1);
      n_total++; if (disp() !== 32'h00595999) $display("FAIL borrow_hr: got %h exp 00595999", disp()); else n_pass++;
      treset = 1'b1; @(negedge clk); treset = 1'b0;
   endtask

   task automatic test_set_wrap();
      set_to(1, 59, 0);
      n_total++; if (disp() !== 32'h01590000) $display("FAIL set_59m: got %h exp 01590000", disp()); else n_pass++;
      pulse_inc(2'd1); p_min = 0;
      n_total++; if (disp() !== 32'h01000000) $display("FAIL min_wrap: got %h exp 01000000", disp()); else n_pass++;
      set_to(99, 0, 0);
      n_total++; if (disp() !== 32'h99000000) $display("FAIL set_99h: got %h exp 99000000", disp()); else n_pass++;
      pulse_inc(2'd2); p_hr = 0;
      n_total++; if (disp() !== 32'h0) $display("FAIL hr_wrap: got %h exp 00000000", disp()); else n_pass++;
      pulse_inc(2'd3);
      n_total++; if (disp() !== 32'h0) $display("FAIL field3: got %h exp 00000000", disp()); else n_pass++;
      pulse_run();
      n_total++; if (state !== S_SET || running !== 1'b0) $display("FAIL run_zero: state %0d run %b exp 0 0", state, running); else n_pass++;
   endtask

   task automatic test_pause();
      set_to(0, 0, 3);
      pulse_run();
      tick(50);
      n_total++; if (disp() !== 32'h00000250) $display("FAIL pre_pause: got %h exp 00000250", disp()); else n_pass++;
      pulse_run();
      n_total++; if (disp() !== 32'h00000250 || state !== S_PAUSE || running !== 1'b0)
         $display("FAIL pause: got %h state %0d run %b exp 00000250 2 0", disp(), state, running); else n_pass++;
      tick(50);
      pulse_inc(2'd0);
      tick(48);
      n_total++; if (disp() !== 32'h00000250) $display("FAIL pause_hold: got %h exp 00000250", disp()); else n_pass++;
      pulse_run();
      n_total++; if (disp() !== 32'h00000250 || running !== 1'b1) $display("FAIL resume: got %h run %b exp 00000250 1", disp(), running); else n_pass++;
      tick(1);
      n_total++; if (disp() !== 32'h00000249) $display("FAIL resume_dec: got %h exp 00000249", disp()); else n_pass++;
      treset = 1'b1; @(negedge clk); treset = 1'b0;
      n_total++; if (disp() !== 32'h00000300 || state !== S_SET) $display("FAIL treset_pause: got %h state %0d exp 00000300 0", disp(), state); else n_pass++;
   endtask

   task automatic test_coincident();
      pulse_run();
      tick(299);
      run_pause = 1'b1; @(negedge clk); run_pause = 1'b0;
      n_total++; if (state !== S_EXP || alarm !== 1'b1 || disp() !== 32'h0)
         $display("FAIL zero_vs_pause: state %0d alarm %b digits %h exp 3 1 00000000", state, alarm, disp()); else n_pass++;
      pulse_run();
      n_total++; if (state !== S_SET || alarm !== 1'b0 || disp() !== 32'h00000300)
         $display("FAIL run_clears: state %0d alarm %b digits %h exp 0 0 00000300", state, alarm, disp()); else n_pass++;
      pulse_run();
      tick(300);
      n_total++; if (alarm !== 1'b1) $display("FAIL second_expiry: alarm %b exp 1", alarm); else n_pass++;
      set_field = 2'd0; set_inc = 1'b1; @(negedge clk); set_inc = 1'b0; set_field = 2'd3;
      n_total++; if (state !== S_SET || alarm !== 1'b0 || disp() !== 32'h00000300)
         $display("FAIL inc_clears: state %0d alarm %b digits %h exp 0 0 00000300", state, alarm, disp()); else n_pass++;
      pulse_run();
      tick(10);
      treset = 1'b1; run_pause = 1'b1; @(negedge clk); treset = 1'b0; run_pause = 1'b0;
      n_total++; if (state !== S_SET || running !== 1'b0 || disp() !== 32'h00000300)
         $display("FAIL treset_vs_run: state %0d run %b digits %h exp 0 0 00000300", state, running, disp()); else n_pass++;
   endtask

   task automatic test_async_reset();
      pulse_run();
      tick(20);
      n_total++; if (disp() !== 32'h00000280) $display("FAIL pre_nreset: got %h exp 00000280", disp()); else n_pass++;
      #2 nreset = 1'b0;
      #1;
      n_total++; if (disp() !== 32'h0 || running !== 1'b0 || alarm !== 1'b0 || state !== S_SET)
         $display("FAIL async_clear: digits %h run %b alarm %b state %0d exp 00000000 0 0 0", disp(), running, alarm, state); else n_pass++;
      @(negedge clk);
      nreset = 1'b1;
      p_sec = 0; p_min = 0; p_hr = 0;
      pulse_run();
      n_total++; if (state !== S_SET || disp() !== 32'h0) $display("FAIL preset_cleared: state %0d digits %h exp 0 00000000", state, disp()); else n_pass++;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_countdown();
      test_alarm_length();
      test_borrow();
      test_set_wrap();
      test_pause();
      test_coincident();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
